// File: rtl/jt5205_feeder.sv
// jt5205_feeder: fetches packed ADPCM bytes from ROM and issues one 4-bit code per cen_lo.
// Define JT5205_FEEDER_LOOP_EN to loop start_addr..end_addr continuously until stop.
module jt5205_feeder #(
    parameter int unsigned AW         = 17,
    parameter bit          HIGH_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_lo,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    typedef enum logic [1:0] {StIdle, StReq, StPlay} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, end_q, end_d;
    logic [7:0]    cur_q, cur_d, nxt_q, nxt_d;
    logic          cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
    logic          phase_q, phase_d, last_q, last_d, primed_q, primed_d;
    logic [3:0]    din_q, din_d;
    logic          done_q, done_d, underrun_q, underrun_d;
    logic          fetch_ok, wr_cur;
`ifdef JT5205_FEEDER_LOOP_EN
    logic [AW-1:0] start_q, start_d;
    logic          cur_end_q, cur_end_d, nxt_end_q, nxt_end_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        cur_vld_d  = cur_vld_q;
        nxt_vld_d  = nxt_vld_q;
        phase_d    = phase_q;
        last_d     = last_q;
        primed_d   = primed_q;
        din_d      = din_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        wr_cur     = 1'b0;
        fetch_ok   = (state_q == StReq) && rom_ok;
`ifdef JT5205_FEEDER_LOOP_EN
        start_d    = start_q;
        cur_end_d  = cur_end_q;
        nxt_end_d  = nxt_end_q;
`endif

        if (state_q != StIdle && cen_lo) begin
            if (cur_vld_q) begin
                if (!phase_q) begin
                    din_d    = HIGH_FIRST ? cur_q[7:4] : cur_q[3:0];
                    phase_d  = 1'b1;
                    primed_d = 1'b1;
                end else begin
                    din_d     = HIGH_FIRST ? cur_q[3:0] : cur_q[7:4];
                    phase_d   = 1'b0;
                    cur_d     = nxt_q;
                    cur_vld_d = nxt_vld_q;
                    nxt_vld_d = 1'b0;
`ifdef JT5205_FEEDER_LOOP_EN
                    done_d    = cur_end_q;
                    cur_end_d = nxt_end_q;
                    nxt_end_d = 1'b0;
`endif
                end
            end else if (!last_q) begin
                if (primed_q) underrun_d = 1'b1;
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        // A refill lands in whichever slot is empty after this clk's shift
        if (fetch_ok) begin
            wr_cur = !cur_vld_d;
            if (wr_cur) begin
                cur_d     = rom_data;
                cur_vld_d = 1'b1;
            end else begin
                nxt_d     = rom_data;
                nxt_vld_d = 1'b1;
            end
            addr_d = addr_q + AW'(1);
`ifdef JT5205_FEEDER_LOOP_EN
            if (addr_q == end_q) addr_d = start_q;
            if (wr_cur) cur_end_d = (addr_q == end_q);
            else        nxt_end_d = (addr_q == end_q);
`else
            if (addr_q == end_q) last_d = 1'b1;
`endif
            state_d = StPlay;
        end else if (state_q == StPlay && state_d == StPlay &&
                     (!cur_vld_q || !nxt_vld_q) && !last_q) begin
            state_d = StReq;
        end

        if (stop) begin
            state_d    = StIdle;
            done_d     = 1'b0;
            din_d      = din_q;
            underrun_d = underrun_q;
        end else if (start) begin
            // Restart from a busy state passes through StPlay so rom_cs drops for a clk
            state_d    = (state_q == StIdle) ? StReq : StPlay;
            addr_d     = start_addr;
            end_d      = end_addr;
            cur_vld_d  = 1'b0;
            nxt_vld_d  = 1'b0;
            phase_d    = 1'b0;
            last_d     = 1'b0;
            primed_d   = 1'b0;
            underrun_d = 1'b0;
            done_d     = 1'b0;
            din_d      = din_q;
`ifdef JT5205_FEEDER_LOOP_EN
            start_d    = start_addr;
            cur_end_d  = 1'b0;
            nxt_end_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            end_q      <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            cur_vld_q  <= 1'b0;
            nxt_vld_q  <= 1'b0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
            primed_q   <= 1'b0;
            din_q      <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef JT5205_FEEDER_LOOP_EN
            start_q    <= '0;
            cur_end_q  <= 1'b0;
            nxt_end_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cur_vld_q  <= cur_vld_d;
            nxt_vld_q  <= nxt_vld_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            primed_q   <= primed_d;
            din_q      <= din_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef JT5205_FEEDER_LOOP_EN
            start_q    <= start_d;
            cur_end_q  <= cur_end_d;
            nxt_end_q  <= nxt_end_d;
`endif
        end
    end

    assign rom_addr = addr_q;
    assign rom_cs   = (state_q == StReq);
    assign busy     = (state_q != StIdle);
    assign din      = din_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: doc/jt5205_feeder.md
Name: jt5205_feeder

Overview:
Byte-to-nibble feeder placed directly upstream of the ADPCM decoder. It fetches packed ADPCM bytes from sample ROM (SDRAM-style cs/ok handshake) between a start and an end address. It presents one 4-bit code per sample strobe (cen_lo) on din and signals end of playback, so the top level can hold the decoder muted while idle.

Parameters:
AW, 17, ROM byte address width.
HIGH_FIRST, 1, 1 = high nibble played first, 0 = low nibble first.

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-high.
cen_lo  input  1  sample strobe, same enable that clocks the decoder's sample update.
start  input  1  one-clk pulse; begins playback (restarts if busy).
stop  input  1  one-clk pulse; aborts playback.
start_addr  input  AW  first byte address, sampled on start.
end_addr  input  AW  last byte address (inclusive), sampled on start.
rom_addr  output  AW  byte address of current fetch.
rom_cs  output  1  fetch request; held high until rom_ok.
rom_data  input  8  ROM byte, valid when rom_ok=1.
rom_ok  input  1  fetch acknowledge, single cycle or level.
din  output  4  ADPCM code to decoder.
busy  output  1  playback active; top uses !busy as decoder mute.
done  output  1  one-clk pulse at normal end of playback.
underrun  output  1  sticky; a code was due with no byte buffered.

Behaviour:
- Reset values: rom_addr=0, rom_cs=0, din=0, busy=0, done=0, underrun=0. All internal valid bits and the primed bit are cleared.
- Storage: cur byte + nxt byte, each with a valid bit; phase bit (0 = first nibble); addr counter (AW bits, wraps modulo 2^AW); last_fetched bit; primed bit.
- FSM: IDLE, REQ, PLAY.
- IDLE: rom_cs=0, busy=0. On start: load addr=start_addr and end register, clear valids, phase, last_fetched, primed and underrun. Go REQ next clk.
- REQ: rom_cs=1, rom_addr=addr. On the rom_ok cycle:
  - write rom_data into cur if cur invalid, else into nxt; set the valid bit.
  - set last_fetched if addr==end_addr; addr<=addr+1.
  - rom_cs drops the following clk; go PLAY.
- PLAY: busy=1. Re-enter REQ whenever (!cur_valid or !nxt_valid) and !last_fetched. A fetch in progress always completes unless aborted.
- On cen_lo in PLAY, with cur_valid:
  - phase 0: din<=first nibble of cur, phase<=1, primed<=1.
  - phase 1: din<=second nibble; phase<=0; cur<=nxt, cur_valid<=nxt_valid, nxt_valid<=0.
  - If a refill write lands in the same clk, it targets the slot that is empty after the shift.
- On cen_lo in PLAY, !cur_valid and !last_fetched:
  - if primed: underrun<=1, din held, phase held.
  - if not primed: silent wait; din held, no flag.
- On cen_lo in PLAY, !cur_valid and last_fetched: busy<=0, done<=1 for one clk, go IDLE. The last nibble therefore lasts one full sample period.
- Latency: din changes on the clk where cen_lo=1. The decoder consumes it at the following cen_lo.
- Wrap: end_addr<start_addr plays through 2^AW-1 -> 0 -> end_addr. start_addr==end_addr plays exactly one byte (2 codes).
- stop in any state: go IDLE, rom_cs<=0, cancel any outstanding fetch, no done pulse, din held.
- start while busy: abort as for stop, force rom_cs=0 for ≥1 clk, then reload and REQ.
- start and stop in the same clk: stop wins.
- rom_ok while rom_cs=0 is ignored.
- Async rst mid-fetch: all state returns to reset values immediately.

Optional Feature:
JT5205_FEEDER_LOOP_EN
- Defined: when the byte at end_addr is fetched, addr reloads start_addr and last_fetched stays 0. Playback loops seamlessly with no gap in din. done pulses one clk when that loop byte's second nibble is issued; busy stays 1 until stop.
- Undefined: single-shot behaviour as above.

Test Plan:
- Reset, then start_addr=0x100, end_addr=0x102, ROM bytes 0x12,0x34,0x56, rom_ok 2 clks after cs, cen_lo every 32 clks -> din sequence 1,2,3,4,5,6. busy falls and done pulses on the 7th cen_lo after the first code.
- HIGH_FIRST=0, same ROM data -> din 2,1,4,3,6,5.
- rom_ok delayed 100 clks with cen_lo every 16 clks mid-stream -> underrun=1, din held at the last code, stream resumes in order when data arrives.
- start_addr=0x1FFFF, end_addr=0x00001 (AW=17) -> fetch order 0x1FFFF, 0x00000, 0x00001, then done.
- stop pulsed during rom_cs=1 -> rom_cs=0 next clk, busy=0, no done. start in the same clk as stop -> stays IDLE.
- With JT5205_FEEDER_LOOP_EN, start=end=0x200, byte 0xA5 -> din A,5,A,5,... continuous, done pulse each loop, busy=1 until stop.
